// File: rtl/if_prefetch_unit_pkg.sv
// Shared encodings for the instruction prefetch stage: NOP, bus widths,
// redirect-select bits, FSM states and the queued entry layout.
package if_prefetch_unit_pkg;

  localparam logic [31:0] NOP_ENC = 32'h0000_0013;

  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;
  localparam logic [WB_SEL_W-1:0] WB_SEL_WORD = '1;

  // Bit positions inside sel_addr_i = {EXC, BR}
  localparam int SEL_BR  = 0;
  localparam int SEL_EXC = 1;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    DISCARD = 2'd1,
    HALT    = 2'd2
  } pf_state_e;

  typedef struct packed {
    logic                err;
    logic [WB_ADR_W-1:0] pc;
    logic [WB_DAT_W-1:0] instr;
  } pf_entry_t;

  localparam int ENTRY_W = $bits(pf_entry_t);

  // Exception target wins over branch target; low bits are dropped here,
  // alignment faults are raised further down the pipe.
  function automatic logic [31:0] redirect_target(input logic [1:0]  sel,
                                                  input logic [31:0] exc,
                                                  input logic [31:0] br);
    return {(sel[SEL_EXC] ? exc[31:2] : br[31:2]), 2'b00};
  endfunction

endpackage

// File: rtl/if_prefetch_unit_fifo.sv
// Show-ahead synchronous FIFO with synchronous clear and occupancy count.
module prefetch_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push, do_pop;

  // A push into a full queue is only taken when the head leaves in the same cycle
  assign do_pop  = pop_i && (count != '0);
  assign do_push = push_i && ((count != CW'(DEPTH)) || do_pop);

  // Storage array, no reset needed: occupancy gates every read
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= din_i;
  end

  // Pointers and occupancy; clear empties the queue in one edge
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign dout_o  = mem[rd_ptr];
  assign count_o = count;
  assign empty_o = (count == '0);

endmodule

// File: rtl/if_prefetch_unit.sv
// Instruction fetch stage: Wishbone classic fetch master feeding a prefetch
// queue in front of the IF/ID register, with redirect flush and fault tagging.
module if_prefetch_unit
  import if_prefetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = 32'h8000_0000,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] NOP_INSTR  = NOP_ENC
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [31:0]         br_j_addr_i,
  input  logic [31:0]         exc_ret_addr_i,
  input  logic [1:0]          sel_addr_i,
  input  logic                stall_i,
  output logic                valid_o,
  output logic [31:0]         instruction_o,
  output logic [31:0]         pc_o,
  output logic                fetch_err_o,
  input  logic [WB_DAT_W-1:0] wbm_dat_i,
  input  logic                wbm_ack_i,
  input  logic                wbm_err_i,
  output logic                wbm_cyc_o,
  output logic                wbm_stb_o,
  output logic [WB_ADR_W-1:0] wbm_addr_o
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  pf_state_e     state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   req_addr_q;
  logic          pending_q;
  logic          redirect, space, issue, cyc, done, push, pop;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  pf_entry_t     push_entry, head;

  assign redirect = |sel_addr_i;

  // A slot is reserved for every open request, so a push can never overflow
  assign space = (fifo_count + CW'(pending_q)) < CW'(FIFO_DEPTH);
  assign issue = (state_q == FETCH) && !pending_q && space && !rst_i;
  assign cyc   = pending_q || issue;
  assign done  = cyc && (wbm_ack_i || wbm_err_i);

  assign wbm_cyc_o  = cyc;
  assign wbm_stb_o  = cyc;
  assign wbm_addr_o = pending_q ? req_addr_q : fetch_pc_q;

  // Responses are queued only in FETCH; a redirect in the same cycle drops them
  assign push = (state_q == FETCH) && done && !redirect;
  assign pop  = valid_o && !stall_i && !redirect;

  assign push_entry.err   = wbm_err_i;
  assign push_entry.pc    = wbm_addr_o;
  assign push_entry.instr = wbm_err_i ? NOP_INSTR : wbm_dat_i;

  prefetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (redirect),
    .push_i  (push),
    .din_i   (push_entry),
    .pop_i   (pop),
    .dout_o  (head),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

  // Next state and fetch address; redirect overrides everything else
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    if (redirect) begin
      fetch_pc_d = redirect_target(sel_addr_i, exc_ret_addr_i, br_j_addr_i);
      state_d    = (cyc && !done) ? DISCARD : FETCH;
    end else begin
      case (state_q)
        FETCH: begin
          if (done && wbm_err_i)  state_d = HALT;
          else if (done)          fetch_pc_d = fetch_pc_q + 32'd4;
        end
        DISCARD: if (done) state_d = FETCH;
        HALT:    state_d = HALT;
        default: state_d = FETCH;
      endcase
    end
  end

  // FSM, fetch PC and the open-request bookkeeping
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= FETCH;
      fetch_pc_q <= RESET_ADDR;
      req_addr_q <= RESET_ADDR;
      pending_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= wbm_addr_o;
      pending_q  <= cyc && !done;
    end
  end

  assign valid_o       = !fifo_empty;
  assign fetch_err_o   = valid_o && head.err;
  assign instruction_o = (valid_o && !head.err) ? head.instr : NOP_INSTR;
  assign pc_o          = head.pc;

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Directed bench for the prefetch unit: a per-cycle vector table plus
// hand-written sequences for queue-full, discard, redirect/ack and reset.
module tb_if_prefetch_unit;
  localparam logic [31:0] R   = 32'h8000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] br_j_addr_i, exc_ret_addr_i;
  logic [1:0]  sel_addr_i;
  logic        stall_i;
  logic        valid_o, fetch_err_o;
  logic [31:0] instruction_o, pc_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i, wbm_err_i;
  logic        wbm_cyc_o, wbm_stb_o;
  logic [31:0] wbm_addr_o;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk_i = ~clk_i;

  // Memory image: every word is a recognisable function of its address
  function automatic logic [31:0] ins(input logic [31:0] a);
    return a ^ 32'h5A5A_0003;
  endfunction

  assign wbm_dat_i = ins(wbm_addr_o);

  if_prefetch_unit #(
    .RESET_ADDR (R),
    .FIFO_DEPTH (4),
    .NOP_INSTR  (NOP)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .br_j_addr_i    (br_j_addr_i),
    .exc_ret_addr_i (exc_ret_addr_i),
    .sel_addr_i     (sel_addr_i),
    .stall_i        (stall_i),
    .valid_o        (valid_o),
    .instruction_o  (instruction_o),
    .pc_o           (pc_o),
    .fetch_err_o    (fetch_err_o),
    .wbm_dat_i      (wbm_dat_i),
    .wbm_ack_i      (wbm_ack_i),
    .wbm_err_i      (wbm_err_i),
    .wbm_cyc_o      (wbm_cyc_o),
    .wbm_stb_o      (wbm_stb_o),
    .wbm_addr_o     (wbm_addr_o)
  );

  typedef struct {
    string       nm;
    logic        rst;
    logic [1:0]  sel;
    logic [31:0] br;
    logic        stall, ack, err;
    logic        x_cyc;
    logic [31:0] x_addr;
    logic        x_valid;
    logic [31:0] x_pc, x_instr;
    logic        x_ferr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(string nm, logic rst, logic [1:0] sel, logic [31:0] br,
                              logic stall, logic ack, logic err,
                              logic x_cyc, logic [31:0] x_addr, logic x_valid,
                              logic [31:0] x_pc, logic [31:0] x_instr, logic x_ferr);
    vec_t v;
    v.nm = nm; v.rst = rst; v.sel = sel; v.br = br;
    v.stall = stall; v.ack = ack; v.err = err;
    v.x_cyc = x_cyc; v.x_addr = x_addr; v.x_valid = x_valid;
    v.x_pc = x_pc; v.x_instr = x_instr; v.x_ferr = x_ferr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1; sel_addr_i = 2'b00; stall_i = 1'b0;
    wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
    br_j_addr_i = '0; exc_ret_addr_i = '0;
    next_cycle();
    next_cycle();
    rst_i = 1'b0;
  endtask

  initial begin
    int acks;
    logic [31:0] last_addr;

    rst_i = 1'b1; sel_addr_i = 2'b00; stall_i = 1'b0;
    wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
    br_j_addr_i = '0; exc_ret_addr_i = '0;
    next_cycle();
    next_cycle();

    //          name            rst sel    br              stl ack err  cyc addr       vld pc        instr          ferr
    tbl.push_back(mk("rst_state",   1, 2'b00, 32'h0,         0, 0, 0,   0, 32'h0,     0, 32'h0,     NOP,           0));
    tbl.push_back(mk("first_req",   0, 2'b00, 32'h0,         0, 1, 0,   1, R,         0, 32'h0,     NOP,           0));
    tbl.push_back(mk("stream_1",    0, 2'b00, 32'h0,         0, 1, 0,   1, R+4,       1, R,         ins(R),        0));
    tbl.push_back(mk("stall_hold",  0, 2'b00, 32'h0,         1, 0, 0,   1, R+8,       1, R+4,       ins(R+4),      0));
    tbl.push_back(mk("err_08",      0, 2'b00, 32'h0,         1, 0, 1,   1, R+8,       1, R+4,       ins(R+4),      0));
    tbl.push_back(mk("halt_pop",    0, 2'b00, 32'h0,         0, 0, 0,   0, 32'h0,     1, R+4,       ins(R+4),      0));
    tbl.push_back(mk("err_head",    0, 2'b00, 32'h0,         1, 1, 0,   0, 32'h0,     1, R+8,       NOP,           1));
    tbl.push_back(mk("err_pop",     0, 2'b00, 32'h0,         0, 0, 0,   0, 32'h0,     1, R+8,       NOP,           1));
    tbl.push_back(mk("halt_empty",  0, 2'b00, 32'h0,         0, 0, 0,   0, 32'h0,     0, 32'h0,     NOP,           0));
    tbl.push_back(mk("redir_halt",  0, 2'b01, 32'h8000_0101, 0, 0, 0,   0, 32'h0,     0, 32'h0,     NOP,           0));
    tbl.push_back(mk("resume",      0, 2'b00, 32'h0,         0, 0, 0,   1, R+32'h100, 0, 32'h0,     NOP,           0));
    tbl.push_back(mk("resume_ack",  0, 2'b00, 32'h0,         0, 1, 0,   1, R+32'h100, 0, 32'h0,     NOP,           0));
    tbl.push_back(mk("resume_head", 0, 2'b00, 32'h0,         0, 0, 0,   1, R+32'h104, 1, R+32'h100, ins(R+32'h100), 0));
    tbl.push_back(mk("resume_drain",0, 2'b00, 32'h0,         0, 0, 0,   1, R+32'h104, 0, 32'h0,     NOP,           0));

    // Table: drive after the edge, compare at the falling edge
    foreach (tbl[i]) begin
      rst_i = tbl[i].rst; sel_addr_i = tbl[i].sel; br_j_addr_i = tbl[i].br;
      exc_ret_addr_i = '0; stall_i = tbl[i].stall;
      wbm_ack_i = tbl[i].ack; wbm_err_i = tbl[i].err;
      @(negedge clk_i);
      n_vec++;
      if ((wbm_cyc_o !== tbl[i].x_cyc) || (wbm_stb_o !== wbm_cyc_o) ||
          (tbl[i].x_cyc && (wbm_addr_o !== tbl[i].x_addr)) ||
          (valid_o !== tbl[i].x_valid) ||
          (tbl[i].x_valid && (pc_o !== tbl[i].x_pc)) ||
          (instruction_o !== tbl[i].x_instr) || (fetch_err_o !== tbl[i].x_ferr)) begin
        n_bad++;
        $display("FAIL %s: got cyc=%b stb=%b addr=%h vld=%b pc=%h ins=%h ferr=%b, expected cyc=%b addr=%h vld=%b pc=%h ins=%h ferr=%b",
                 tbl[i].nm, wbm_cyc_o, wbm_stb_o, wbm_addr_o, valid_o, pc_o, instruction_o, fetch_err_o,
                 tbl[i].x_cyc, tbl[i].x_addr, tbl[i].x_valid, tbl[i].x_pc, tbl[i].x_instr, tbl[i].x_ferr);
      end
      next_cycle();
    end

    // Queue full under stall: exactly DEPTH accepted, one pop frees one request
    do_reset();
    stall_i = 1'b1; wbm_ack_i = 1'b1; acks = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      if (wbm_cyc_o) acks++;
      next_cycle();
    end
    chk("full_acks", acks, 4);
    @(negedge clk_i);
    chk("full_cyc_low", wbm_cyc_o, 0);
    chk("full_head_pc", pc_o, R);
    next_cycle();
    stall_i = 1'b0; wbm_ack_i = 1'b0;
    @(negedge clk_i);
    chk("pop_cyc_low", wbm_cyc_o, 0);
    next_cycle();
    stall_i = 1'b1; wbm_ack_i = 1'b1; acks = 0; last_addr = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      if (wbm_cyc_o) begin acks++; last_addr = wbm_addr_o; end
      next_cycle();
    end
    chk("one_release", acks, 1);
    chk("release_addr", last_addr, R+32'h10);
    chk("after_pop_pc", pc_o, R+4);

    // Redirect while a request is open: late data dropped, then fetch target
    do_reset();
    sel_addr_i = 2'b01; br_j_addr_i = 32'h8000_0100;
    @(negedge clk_i);
    chk("dsc_open_addr", wbm_addr_o, R);
    next_cycle();
    sel_addr_i = 2'b00;
    @(negedge clk_i);
    chk("dsc_hold_cyc", wbm_cyc_o, 1);
    chk("dsc_hold_addr", wbm_addr_o, R);
    next_cycle();
    @(negedge clk_i);
    chk("dsc_hold_addr2", wbm_addr_o, R);
    next_cycle();
    wbm_ack_i = 1'b1;
    @(negedge clk_i);
    chk("dsc_late_ack_vld", valid_o, 0);
    next_cycle();
    wbm_ack_i = 1'b0;
    @(negedge clk_i);
    chk("dsc_target_addr", wbm_addr_o, 32'h8000_0100);
    chk("dsc_no_data", valid_o, 0);
    next_cycle();
    wbm_ack_i = 1'b1;
    next_cycle();
    wbm_ack_i = 1'b0;
    @(negedge clk_i);
    chk("dsc_target_pc", pc_o, 32'h8000_0100);
    chk("dsc_target_ins", instruction_o, ins(32'h8000_0100));

    // Exception and branch together, coinciding with an ack
    do_reset();
    wbm_ack_i = 1'b1;
    next_cycle();
    sel_addr_i = 2'b11; exc_ret_addr_i = 32'h8000_0004; br_j_addr_i = 32'h8000_0200;
    @(negedge clk_i);
    chk("exc_pre_vld", valid_o, 1);
    next_cycle();
    sel_addr_i = 2'b00; wbm_ack_i = 1'b0;
    @(negedge clk_i);
    chk("exc_flushed", valid_o, 0);
    chk("exc_next_addr", wbm_addr_o, 32'h8000_0004);
    chk("exc_cyc", wbm_cyc_o, 1);

    // Reset during an open request with the queue half full
    do_reset();
    stall_i = 1'b1; wbm_ack_i = 1'b1;
    next_cycle();
    next_cycle();
    wbm_ack_i = 1'b0;
    next_cycle();
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("rst_open_cyc", wbm_cyc_o, 1);
    next_cycle();
    wbm_ack_i = 1'b1;
    @(negedge clk_i);
    chk("rst_cyc_low", wbm_cyc_o, 0);
    chk("rst_vld_low", valid_o, 0);
    next_cycle();
    rst_i = 1'b0; wbm_ack_i = 1'b0;
    @(negedge clk_i);
    chk("rst_refetch", wbm_addr_o, R);
    chk("rst_refetch_cyc", wbm_cyc_o, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
